// File: rtl/ram_arbiter_2.sv
// Two-requester arbiter in front of a single-port RAM; IDLE -> ACCESS -> RESP, all outputs registered.
// Latency: ack 1 cycle after the req is sampled, rvalid/rdata 3 cycles after; back-pressure by holding req until ack.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module ram_arbiter_2 #(
    parameter  int SIZE  = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [SIZE-1:0] wdata0,
    input  logic [SIZE-1:0] wdata1,
    output logic            ack0,
    output logic            ack1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [SIZE-1:0] rdata0,
    output logic [SIZE-1:0] rdata1,
    output logic [AW-1:0]   ram_address,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    input  logic [SIZE-1:0] ram_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic            win_q, win_d;
    logic            we_q, we_d;
    logic [1:0]      ack_q, ack_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic [SIZE-1:0] rdata0_q, rdata0_d;
    logic [SIZE-1:0] rdata1_q, rdata1_d;
    logic [AW-1:0]   ram_address_q, ram_address_d;
    logic [SIZE-1:0] ram_write_data_q, ram_write_data_d;
    logic            ram_write_en_q, ram_write_en_d;
    logic            pick;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic            prio_q, prio_d;
`endif

    always_comb begin
        state_d          = state_q;
        win_d            = win_q;
        we_d             = we_q;
        ack_d            = '0;
        rvalid_d         = '0;
        rdata0_d         = rdata0_q;
        rdata1_d         = rdata1_q;
        ram_address_d    = ram_address_q;
        ram_write_data_d = ram_write_data_q;
        ram_write_en_d   = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        prio_d           = prio_q;
        // prio_q names the requester that wins a tie
        pick             = (req0 && req1) ? prio_q : !req0;
`else
        pick             = !req0;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d            = pick;
                    we_d             = pick ? we1 : we0;
                    ram_address_d    = pick ? addr1 : addr0;
                    ram_write_data_d = pick ? wdata1 : wdata0;
                    ram_write_en_d   = pick ? we1 : we0;
                    ack_d[pick]      = 1'b1;
                    state_d          = ACCESS;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    prio_d           = !pick;
`endif
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                // RAM data for the address presented in ACCESS is valid now
                if (!we_q) begin
                    rvalid_d[win_q] = 1'b1;
                    if (win_q) rdata1_d = ram_read_data;
                    else       rdata0_d = ram_read_data;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            win_q            <= 1'b0;
            we_q             <= 1'b0;
            ack_q            <= '0;
            rvalid_q         <= '0;
            rdata0_q         <= '0;
            rdata1_q         <= '0;
            ram_address_q    <= '0;
            ram_write_data_q <= '0;
            ram_write_en_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            win_q            <= win_d;
            we_q             <= we_d;
            ack_q            <= ack_d;
            rvalid_q         <= rvalid_d;
            rdata0_q         <= rdata0_d;
            rdata1_q         <= rdata1_d;
            ram_address_q    <= ram_address_d;
            ram_write_data_q <= ram_write_data_d;
            ram_write_en_q   <= ram_write_en_d;
        end
    end

`ifdef RAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end
`endif

    assign ack0           = ack_q[0];
    assign ack1           = ack_q[1];
    assign rvalid0        = rvalid_q[0];
    assign rvalid1        = rvalid_q[1];
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign ram_address    = ram_address_q;
    assign ram_write_data = ram_write_data_q;
    assign ram_write_en   = ram_write_en_q;

endmodule

// File: tb/tb_ram_arbiter_2.sv
// Randomized bench for ram_arbiter_2 with a transaction-level model of arbitration and RAM contents.
module tb_ram_arbiter_2;

    localparam int SIZE  = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0, req1, we0, we1;
    logic [AW-1:0]   addr0, addr1;
    logic [SIZE-1:0] wdata0, wdata1;
    logic            ack0, ack1, rvalid0, rvalid1;
    logic [SIZE-1:0] rdata0, rdata1;
    logic [AW-1:0]   ram_address;
    logic [SIZE-1:0] ram_write_data;
    logic            ram_write_en;
    logic [SIZE-1:0] ram_read_data;

    int total = 0;
    int bad   = 0;

    ram_arbiter_2 #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_write_en(ram_write_en), .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM; unwritten locations read as addr ^ 0x5A.
    logic [SIZE-1:0] ram_mem [DEPTH];
    bit              ram_written [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) begin
            ram_mem[ram_address]     <= ram_write_data;
            ram_written[ram_address] <= 1'b1;
        end
        ram_read_data <= ram_written[ram_address] ? ram_mem[ram_address] : (ram_address ^ 8'h5A);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("ack_mutex", 32'(ack0 & ack1), 32'd0);
            check("rvalid_mutex", 32'(rvalid0 & rvalid1), 32'd0);
        end
    end

    // Reference model state
    logic [SIZE-1:0] model_mem [DEPTH];
    logic [SIZE-1:0] last_rd [2];
    bit              pend [2];
    bit              pwe [2];
    logic [AW-1:0]   pa [2];
    logic [SIZE-1:0] pd [2];
    bit              prio;

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return AW'(DEPTH - 1);
            2:       return AW'($urandom_range(0, 7));
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic drive();
        req0 = pend[0]; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0];
        req1 = pend[1]; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1];
        // a dropped requester's other inputs must be ignored
        if (!pend[0]) begin addr0 = AW'($urandom); we0 = 1'($urandom); end
        if (!pend[1]) begin addr1 = AW'($urandom); we1 = 1'($urandom); end
    endtask

    // mode 0: random new requests, 1: force both to issue reads, 2: no new requests
    task automatic run_slot(input int mode);
        bit w;
        logic [SIZE-1:0] exp_rd;
        for (int n = 0; n < 2; n++) begin
            if (!pend[n] && mode != 2 && (mode == 1 || $urandom_range(0, 2) != 0)) begin
                pend[n] = 1'b1;
                pwe[n]  = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                pa[n]   = rand_addr();
                pd[n]   = SIZE'($urandom);
            end
        end
        drive();
        if (!pend[0] && !pend[1]) begin
            @(negedge clk);
            check("idle_no_ack", {30'd0, ack1, ack0}, 32'd0);
            return;
        end
`ifdef RAM_ARB_ROUND_ROBIN_EN
        w = (pend[0] && pend[1]) ? prio : pend[1];
`else
        w = !pend[0];
`endif
        @(negedge clk);
        check("grant", {30'd0, ack1, ack0}, w ? 32'd2 : 32'd1);
        check("acc_wen", 32'(ram_write_en), 32'(pwe[w]));
        check("acc_addr", 32'(ram_address), 32'(pa[w]));
        if (pwe[w]) check("acc_wdata", 32'(ram_write_data), 32'(pd[w]));
        exp_rd = model_mem[pa[w]];
        if (pwe[w]) model_mem[pa[w]] = pd[w];
        prio    = !w;
        pend[w] = 1'b0;
        drive();
        @(negedge clk);
        check("resp_quiet", {28'd0, ram_write_en, ack1, ack0, rvalid0 | rvalid1}, 32'd0);
        @(negedge clk);
        if (!pwe[w]) last_rd[w] = exp_rd;
        check("rvalid", {30'd0, rvalid1, rvalid0}, pwe[w] ? 32'd0 : (w ? 32'd2 : 32'd1));
        check("rdata0", 32'(rdata0), 32'(last_rd[0]));
        check("rdata1", 32'(rdata1), 32'(last_rd[1]));
    endtask

    task automatic model_reset();
        prio = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        pend[0] = 1'b0;  pend[1] = 1'b0;
    endtask

    task automatic queue_op(input int n, input bit wr, input logic [AW-1:0] a, input logic [SIZE-1:0] d);
        pend[n] = 1'b1; pwe[n] = wr; pa[n] = a; pd[n] = d;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = SIZE'(i) ^ 8'h5A;
        for (int n = 0; n < 2; n++) begin pwe[n] = 1'b0; pa[n] = '0; pd[n] = '0; end
        model_reset();
        rst = 1'b1;
        queue_op(0, 1'b1, 8'd5, 8'hA5);
        drive();
        repeat (2) @(negedge clk);
        check("rst_outs", {ack1, ack0, rvalid1, rvalid0, ram_write_en, 27'd0}, 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_wdata", 32'(ram_write_data), 32'd0);
        check("rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
        rst = 1'b0;
        // first edge after release arbitrates
        run_slot(2);
        queue_op(1, 1'b0, 8'd5, 8'h00);
        run_slot(2);
        repeat (4) run_slot(1);
        while (pend[0] || pend[1]) run_slot(2);
        for (int i = 0; i < 200; i++) run_slot(0);
        while (pend[0] || pend[1]) run_slot(2);

        // reset during the ACCESS cycle of a write aborts it
        queue_op(0, 1'b1, 8'd7, 8'h3C);
        drive();
        @(posedge clk);
        #1;
        check("abort_wen_before", 32'(ram_write_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_wen_after", 32'(ram_write_en), 32'd0);
        check("abort_ack", {30'd0, ack1, ack0}, 32'd0);
        model_reset();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", {29'd0, ack1 | ack0, rvalid1 | rvalid0, ram_write_en}, 32'd0);
        end
        queue_op(0, 1'b0, 8'd7, 8'h00);
        run_slot(2);

        queue_op(1, 1'b1, 8'hFF, 8'hC3);
        run_slot(2);
        queue_op(0, 1'b1, 8'h00, 8'h96);
        run_slot(2);
        queue_op(0, 1'b0, 8'hFF, 8'h00);
        queue_op(1, 1'b0, 8'h00, 8'h00);
        run_slot(2);
        run_slot(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
